icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter NLINES, default 16, number of cache lines (power of 2).
REQ-002 Parameter NWORDS, default 4, 32-bit words per line (power of 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_req  input  1  fetch request valid this cycle.
REQ-006 cpu_addr  input  32  byte address of fetch (word aligned; bits [1:0] ignored).
REQ-007 cpu_data  output  32  instruction word for cpu_addr.
REQ-008 cpu_stall  output  1  high when cpu_data is not valid this cycle; drives PC/IF-ID hold.
REQ-009 inval  input  1  one-cycle pulse: invalidate all lines.
REQ-010 mem_req  output  1  backing-memory beat request.
REQ-011 mem_addr  output  32  word-aligned byte address of requested beat.
REQ-012 mem_ack  input  1  beat accepted; mem_rdata valid this cycle.
REQ-013 mem_rdata  input  32  beat data.
REQ-014 miss_cnt  output  16  saturating count of refills started.

Function
REQ-015 Address split: offset = addr[log2(NWORDS)+1:2], index = next log2(NLINES) bits, tag = remaining upper bits (24 bits at defaults).
REQ-016 Storage: per line one valid bit, one tag, NWORDS data words, all held in flops.
REQ-017 FSM states IDLE, REFILL, FILLED; reset state IDLE.
REQ-018 Hit = cpu_req & valid[index] & tag match, evaluated combinationally in IDLE; on hit cpu_data = stored word same cycle, cpu_stall = 0 (zero-cycle hit latency).
REQ-019 cpu_req = 0: cpu_stall = 0, cpu_data = 0.
REQ-020 Miss in IDLE: cpu_stall = 1 that cycle; next edge latch line base address (offset bits zeroed), clear beat counter, enter REFILL, increment miss_cnt (holds at 16'hFFFF).
REQ-021 REFILL: mem_req = 1, mem_addr = base + 4*beat; mem_addr stable until mem_ack.
REQ-022 On each mem_ack: write mem_rdata into word[beat] of latched index, increment beat; on last beat (beat = NWORDS-1) write tag, set valid, enter FILLED.
REQ-023 Refill order always word 0 to NWORDS-1; no critical-word-first.
REQ-024 cpu_stall = 1 throughout REFILL and FILLED.
REQ-025 FILLED lasts exactly one cycle, then IDLE; hit re-evaluated in IDLE with current cpu_addr.
REQ-026 cpu_addr changing during REFILL (e.g. pipeline flush redirect) does not alter the in-flight refill; the filled line stays valid; new address is looked up in IDLE.
REQ-027 mem_req = 0 in IDLE and FILLED; mem_addr = 0 when mem_req = 0.
REQ-028 inval in IDLE: all valid bits cleared next edge; lookup in the inval cycle uses pre-clear valids.
REQ-029 inval during REFILL: all valid bits cleared; sticky drop flag set; refill runs to completion but does not set valid for that line; flag cleared on entry to IDLE.
REQ-030 inval and last-beat mem_ack same cycle: inval wins, line left invalid.
REQ-031 mem_ack outside REFILL ignored.

Reset
REQ-032 rst high at any edge: state IDLE, all valid bits 0, beat 0, drop flag 0, miss_cnt 0; tags/data unreset.
REQ-033 During and after reset: mem_req = 0, mem_addr = 0, cpu_data = 0, cpu_stall = 0 when cpu_req = 0.
REQ-034 rst during REFILL abandons transaction; mem_req low next cycle; partial line stays invalid.

Verification
REQ-035 Cold miss: cpu_req=1, addr 0x0000_0040, mem acks beat per cycle -> mem_addr 0x40,0x44,0x48,0x4C; stall 6 cycles; then hit, miss_cnt=1.
REQ-036 Hit sweep: after REQ-035 fill, addrs 0x40..0x4C back-to-back -> cpu_stall=0 every cycle, data matches beats.
REQ-037 Conflict: fill 0x0000_0040 then 0x0000_0140 (same index 4, tag differ) -> second misses, then 0x40 misses again; miss_cnt=3.
REQ-038 Backpressure: mem_ack delayed 3 cycles per beat -> mem_addr held constant, no beat skipped, stall ends 1 cycle after FILLED.
REQ-039 inval mid-refill of 0x80 at beat 2 -> refill completes, subsequent 0x80 fetch misses again.
REQ-040 rst asserted at beat 1 of refill -> mem_req 0 next cycle, miss_cnt 0, re-fetch of same addr misses.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with zero-cycle hits and an in-order
// line refill from a single-beat-per-ack backing memory.

module icache_line #(
    parameter int NWORDS = 4,
    parameter int TAG_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [$clog2(NWORDS)-1:0] wr_word,
    input  logic [31:0]              wr_data,
    input  logic                     fill_done,
    input  logic                     keep,
    input  logic [TAG_W-1:0]         tag_in,
    output logic                     valid,
    output logic [TAG_W-1:0]         tag,
    output logic [NWORDS-1:0][31:0]  data
);
    // clr beats a same-cycle fill completion, so a line dropped at its last beat stays invalid
    always_ff @(posedge clk) begin
        if (rst || clr)
            valid <= 1'b0;
        else if (fill_done && keep)
            valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fill_done)
            tag <= tag_in;
        if (wr_en)
            data[wr_word] <= wr_data;
    end
endmodule

module icache_dm #(
    parameter int NLINES = 16,
    parameter int NWORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_data,
    output logic        cpu_stall,
    input  logic        inval,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] miss_cnt
);
    localparam int OFF_W = $clog2(NWORDS);
    localparam int IDX_W = $clog2(NLINES);
    localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
    localparam int LA_W  = TAG_W + IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, FILLED} state_t;

    state_t            state;
    logic [LA_W-1:0]   base_la;
    logic [OFF_W-1:0]  beat;
    logic              drop;

    logic [NLINES-1:0]                   line_valid;
    logic [NLINES-1:0][TAG_W-1:0]        line_tag;
    logic [NLINES-1:0][NWORDS-1:0][31:0] line_data;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic             hit, ack, last;
    logic             unused_addr_lsb;

    assign req_off  = cpu_addr[OFF_W+1:2];
    assign req_idx  = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign req_tag  = cpu_addr[31:IDX_W+OFF_W+2];
    assign fill_idx = base_la[IDX_W-1:0];
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign hit = (state == IDLE) && cpu_req && line_valid[req_idx] &&
                 (line_tag[req_idx] == req_tag);

    assign cpu_data  = hit ? line_data[req_idx][req_off] : 32'd0;
    assign cpu_stall = (state != IDLE) || (cpu_req && !hit);

    assign mem_req  = (state == REFILL);
    assign mem_addr = mem_req ? {base_la, beat, 2'b00} : 32'd0;

    // mem_ack is only meaningful while a beat is being requested
    assign ack  = mem_req && mem_ack;
    assign last = ack && (beat == OFF_W'(NWORDS - 1));

    for (genvar gi = 0; gi < NLINES; gi++) begin : g_line
        logic sel;
        assign sel = (fill_idx == IDX_W'(gi));

        icache_line #(.NWORDS(NWORDS), .TAG_W(TAG_W)) u_line (
            .clk       (clk),
            .rst       (rst),
            .clr       (inval),
            .wr_en     (ack && sel),
            .wr_word   (beat),
            .wr_data   (mem_rdata),
            .fill_done (last && sel),
            .keep      (!drop),
            .tag_in    (base_la[LA_W-1:IDX_W]),
            .valid     (line_valid[gi]),
            .tag       (line_tag[gi]),
            .data      (line_data[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= '0;
            drop     <= 1'b0;
            miss_cnt <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req && !hit) begin
                        base_la <= cpu_addr[31:OFF_W+2];
                        beat    <= '0;
                        drop    <= 1'b0;
                        state   <= REFILL;
                        if (miss_cnt != 16'hFFFF)
                            miss_cnt <= miss_cnt + 16'd1;
                    end
                end
                REFILL: begin
                    // a flush mid-refill still finishes the burst but must not publish the line
                    if (inval)
                        drop <= 1'b1;
                    if (ack) begin
                        beat <= beat + 1'b1;
                        if (last)
                            state <= FILLED;
                    end
                end
                FILLED: begin
                    drop  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed vector table, hand-built corner
// sequences, and random traffic against a line-level reference model.

module tb_icache_dm;
    localparam int NL = 16;
    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_data;
    logic        cpu_stall;
    logic        inval = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [15:0] miss_cnt;

    always #5 clk = ~clk;

    icache_dm #(.NLINES(NL), .NWORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_stall (cpu_stall),
        .inval     (inval),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .miss_cnt  (miss_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // backing memory contents: a fixed function of the word address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:2], 2'b01, ~a[17:2]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference model: which line address each slot holds, plus refill progress
    bit          m_busy, m_filled, m_drop;
    logic [27:0] m_la;
    int          m_beat;
    logic [15:0] m_miss;
    bit          mv [NL];
    logic [27:0] mla[NL];
    int          wcnt, ack_delay;

    logic        s_stall, s_mreq;
    logic [31:0] s_data, s_maddr;
    logic [15:0] s_miss;

    task automatic model_reset();
        m_busy = 0; m_filled = 0; m_drop = 0; m_beat = 0; m_miss = 16'd0; wcnt = 0;
        for (int i = 0; i < NL; i++) mv[i] = 0;
    endtask

    task automatic step(input bit req, input logic [31:0] addr, input bit inv, input bit ack);
        logic [27:0] la;
        int          idx;
        bit          hit, e_stall, e_mreq;
        logic [31:0] e_data, e_maddr;
        @(negedge clk);
        la = addr[31:4];
        idx = int'(addr[7:4]);
        hit = 0;
        if (m_busy) begin
            e_stall = 1; e_data = 0; e_mreq = 1;
            e_maddr = {m_la, 4'b0000} + 32'(4 * m_beat);
        end else if (m_filled) begin
            e_stall = 1; e_data = 0; e_mreq = 0; e_maddr = 0;
        end else begin
            hit = req && mv[idx] && (mla[idx] == la);
            e_stall = req && !hit;
            e_data = hit ? memf(addr) : 32'd0;
            e_mreq = 0; e_maddr = 0;
        end
        rst = 0; cpu_req = req; cpu_addr = addr; inval = inv; mem_ack = ack;
        mem_rdata = (ack && m_busy) ? memf(e_maddr) : $urandom();
        #1;
        s_stall = cpu_stall; s_data = cpu_data; s_mreq = mem_req; s_maddr = mem_addr; s_miss = miss_cnt;
        chk("stall", {31'd0, cpu_stall}, {31'd0, e_stall});
        chk("data", cpu_data, e_data);
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_mreq});
        chk("mem_addr", mem_addr, e_maddr);
        chk("miss_cnt", {16'd0, miss_cnt}, {16'd0, m_miss});
        if (inv)
            for (int i = 0; i < NL; i++) mv[i] = 0;
        if (m_busy) begin
            if (inv) m_drop = 1;
            wcnt = ack ? 0 : wcnt + 1;
            if (ack) begin
                m_beat++;
                if (m_beat == NW) begin
                    m_busy = 0; m_filled = 1;
                    if (!m_drop && !inv) begin
                        mv[int'(m_la[3:0])] = 1;
                        mla[int'(m_la[3:0])] = m_la;
                    end
                end
            end
        end else if (m_filled) begin
            m_filled = 0;
        end else if (req && !hit) begin
            m_busy = 1; m_la = la; m_beat = 0; m_drop = 0; wcnt = 0;
            if (m_miss != 16'hFFFF) m_miss++;
        end
    endtask

    function automatic bit auto_ack();
        return m_busy && (wcnt >= ack_delay);
    endfunction

    // keep fetching addr until the cache stops stalling; returns stall cycles seen
    task automatic fetch(input logic [31:0] addr, output int stalls);
        bit done;
        done = 0; stalls = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            step(1, addr, 0, auto_ack());
            if (s_stall) stalls++;
            else done = 1;
        end
        chk("fetch_done", {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; cpu_req = 0; inval = 0; mem_ack = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
            chk("rst_data", cpu_data, 32'd0);
            chk("rst_miss", {16'd0, miss_cnt}, 32'd0);
        end
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          ack;
        bit          x_stall;
        bit          x_mreq;
        logic [31:0] x_maddr;
        logic [31:0] x_data;
        logic [15:0] x_miss;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int st;
        tbl[0]  = '{1, 32'h40, 0, 1, 0, 32'h00, 32'd0, 16'd0};
        tbl[1]  = '{1, 32'h40, 1, 1, 1, 32'h40, 32'd0, 16'd1};
        tbl[2]  = '{1, 32'h40, 1, 1, 1, 32'h44, 32'd0, 16'd1};
        tbl[3]  = '{1, 32'h40, 1, 1, 1, 32'h48, 32'd0, 16'd1};
        tbl[4]  = '{1, 32'h40, 1, 1, 1, 32'h4C, 32'd0, 16'd1};
        tbl[5]  = '{1, 32'h40, 0, 1, 0, 32'h00, 32'd0, 16'd1};
        tbl[6]  = '{1, 32'h40, 0, 0, 0, 32'h00, memf(32'h40), 16'd1};
        tbl[7]  = '{1, 32'h44, 0, 0, 0, 32'h00, memf(32'h44), 16'd1};
        tbl[8]  = '{1, 32'h48, 0, 0, 0, 32'h00, memf(32'h48), 16'd1};
        tbl[9]  = '{1, 32'h4C, 0, 0, 0, 32'h00, memf(32'h4C), 16'd1};
        tbl[10] = '{0, 32'h4C, 0, 0, 0, 32'h00, 32'd0, 16'd1};

        ack_delay = 0;
        model_reset();
        do_reset();

        // cold miss of 0x40 followed by a back-to-back hit sweep
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].req, tbl[i].addr, 0, tbl[i].ack);
            chk("tbl_stall", {31'd0, s_stall}, {31'd0, tbl[i].x_stall});
            chk("tbl_mem_req", {31'd0, s_mreq}, {31'd0, tbl[i].x_mreq});
            chk("tbl_mem_addr", s_maddr, tbl[i].x_maddr);
            chk("tbl_data", s_data, tbl[i].x_data);
            chk("tbl_miss", {16'd0, s_miss}, {16'd0, tbl[i].x_miss});
        end

        // conflict on index 4
        fetch(32'h140, st);
        chk("conflict_stalls", st, 6);
        fetch(32'h40, st);
        chk("conflict_remiss", st, 6);
        chk("conflict_cnt", {16'd0, s_miss}, 32'd3);

        // backpressure: three idle cycles before each ack
        ack_delay = 3;
        fetch(32'h300, st);
        chk("bp_stalls", st, 18);
        ack_delay = 0;
        for (int i = 0; i < NW; i++) begin
            step(1, 32'h300 + 32'(4 * i), 0, 0);
            chk("bp_hit", {31'd0, s_stall}, 32'd0);
        end

        // invalidate while beat 2 of 0x80 is acked
        step(1, 32'h80, 0, 0);
        step(1, 32'h80, 0, 1);
        step(1, 32'h80, 0, 1);
        step(1, 32'h80, 1, 1);
        fetch(32'h80, st);
        chk("inval_mid_stalls", st, 8);
        chk("inval_mid_cnt", {16'd0, s_miss}, 32'd6);

        // inval in IDLE: this cycle still hits, the next one misses
        step(1, 32'h84, 1, 0);
        chk("inval_pre_clear", {31'd0, s_stall}, 32'd0);
        fetch(32'h84, st);
        chk("inval_post_clear", st, 6);

        // inval coincides with the last beat
        step(1, 32'h500, 0, 0);
        step(1, 32'h500, 0, 1);
        step(1, 32'h500, 0, 1);
        step(1, 32'h500, 0, 1);
        step(1, 32'h500, 1, 1);
        fetch(32'h500, st);
        chk("inval_last_stalls", st, 7);
        chk("inval_last_cnt", {16'd0, s_miss}, 32'd9);

        // reset abandons a refill at beat 1
        step(1, 32'h200, 0, 0);
        step(1, 32'h200, 0, 1);
        do_reset();
        step(1, 32'h200, 0, 0);
        chk("rst_refetch_miss", {31'd0, s_stall}, 32'd1);
        fetch(32'h200, st);
        chk("rst_refetch_cnt", {16'd0, s_miss}, 32'd1);

        // random traffic, random backpressure, spurious acks, redirects mid-refill
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
                32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a = a | 32'h1000_0000;
            step($urandom_range(0, 7) != 0, a, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
